dram_rd_arbiter: RTL

Shares the single DRAM read port between the three loaders: bias buffer (requester 0), weight FIFO (1) and ifmap FIFO (2). Each requester posts a burst descriptor (base address, length). The arbiter grants one requester at a time in round-robin order, then issues one address per cycle, throttled by that destination's space flag. It returns a read-valid strobe and a destination select aligned with the DRAM read latency, and pulses a per-requester done flag. It replaces the fixed, hard-coded address sequencing in the top controller.

---
 rtl/dram_rd_arbiter_if.sv | 42 ++++
 rtl/dram_rd_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dram_rd_arbiter_if.sv
// DRAM read-port arbiter bus: requester descriptors, destination flow
// control and the shared read strobe/steering returned to the datapath.
interface dram_rd_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
);
    logic [2:0]        req;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [ADDR_W-1:0] req_addr2;
    logic [LEN_W-1:0]  req_len0;
    logic [LEN_W-1:0]  req_len1;
    logic [LEN_W-1:0]  req_len2;
    logic [2:0]        dst_ready;
    logic [ADDR_W-1:0] DRAMreadAddr;
    logic              DRAMreadEn;
    logic              rd_valid;
    logic [1:0]        rd_sel;
    logic [2:0]        grant;
    logic [2:0]        done;
    logic              busy;

    modport master (
        output req,
        output req_addr0, req_addr1, req_addr2,
        output req_len0, req_len1, req_len2,
        output dst_ready,
        input  DRAMreadAddr, DRAMreadEn,
        input  rd_valid, rd_sel,
        input  grant, done, busy
    );

    modport slave (
        input  req,
        input  req_addr0, req_addr1, req_addr2,
        input  req_len0, req_len1, req_len2,
        input  dst_ready,
        output DRAMreadAddr, DRAMreadEn,
        output rd_valid, rd_sel,
        output grant, done, busy
    );
endinterface

// File: rtl/dram_rd_arbiter.sv
// Round-robin owner of the single DRAM read port for the bias, weight and
// ifmap loaders; issues one address per cycle and aligns data-valid steering.
module dram_rd_arbiter #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst,
    dram_rd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [1:0]        gIdx;
    logic [1:0]        gIdxNext;
    logic [1:0]        lastWin;
    logic [1:0]        lastWinNext;
    logic [ADDR_W-1:0] curAddr;
    logic [ADDR_W-1:0] curAddrNext;
    logic [LEN_W-1:0]  curCnt;
    logic [LEN_W-1:0]  curCntNext;
    logic [2:0]        drainCnt;
    logic [2:0]        drainCntNext;

    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic [1:0]        winner;
    logic [ADDR_W-1:0] descAddr;
    logic [LEN_W-1:0]  descLen;
    logic              readEn;
    logic              doneNow;

    logic [RD_LAT-1:0] vPipe;
    logic [1:0]        sPipe [RD_LAT];
    logic [1:0]        selHold;

    function automatic logic [1:0] nextIdx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order last+1, last+2, last keeps any waiter ahead of a repeat.
    always_comb begin
        cand1 = nextIdx(lastWin);
        cand2 = nextIdx(cand1);
        if (bus.req[cand1]) begin
            winner = cand1;
        end else if (bus.req[cand2]) begin
            winner = cand2;
        end else begin
            winner = lastWin;
        end
    end

    always_comb begin
        descAddr = bus.req_addr0;
        descLen  = bus.req_len0;
        if (winner == 2'd1) begin
            descAddr = bus.req_addr1;
            descLen  = bus.req_len1;
        end else if (winner == 2'd2) begin
            descAddr = bus.req_addr2;
            descLen  = bus.req_len2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gIdx     <= 2'd0;
            lastWin  <= 2'd2;
            curAddr  <= '0;
            curCnt   <= '0;
            drainCnt <= '0;
        end else begin
            state    <= stateNext;
            gIdx     <= gIdxNext;
            lastWin  <= lastWinNext;
            curAddr  <= curAddrNext;
            curCnt   <= curCntNext;
            drainCnt <= drainCntNext;
        end
    end

    always_comb begin
        stateNext    = state;
        gIdxNext     = gIdx;
        lastWinNext  = lastWin;
        curAddrNext  = curAddr;
        curCntNext   = curCnt;
        drainCntNext = drainCnt;
        readEn       = 1'b0;
        doneNow      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    stateNext   = ISSUE;
                    gIdxNext    = winner;
                    lastWinNext = winner;
                    curAddrNext = descAddr;
                    curCntNext  = descLen;
                end
            end
            ISSUE: begin
                if (curCnt == '0) begin
                    doneNow   = 1'b1;
                    stateNext = IDLE;
                end else if (bus.dst_ready[gIdx]) begin
                    readEn      = 1'b1;
                    curAddrNext = curAddr + 1'b1;
                    curCntNext  = curCnt - 1'b1;
                    if (curCnt == LEN_W'(1)) begin
                        stateNext    = DRAIN;
                        drainCntNext = 3'(RD_LAT - 1);
                    end
                end
            end
            DRAIN: begin
                // Final cycle lines up with rd_valid of the last beat.
                if (drainCnt == '0) begin
                    doneNow   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    drainCntNext = drainCnt - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vPipe   <= '0;
            selHold <= 2'd0;
            for (int i = 0; i < RD_LAT; i++) begin
                sPipe[i] <= 2'd0;
            end
        end else begin
            vPipe[0] <= readEn;
            sPipe[0] <= gIdx;
            for (int i = 1; i < RD_LAT; i++) begin
                vPipe[i] <= vPipe[i-1];
                sPipe[i] <= sPipe[i-1];
            end
            if (vPipe[RD_LAT-1]) begin
                selHold <= sPipe[RD_LAT-1];
            end
        end
    end

    assign bus.DRAMreadAddr = curAddr;
    assign bus.DRAMreadEn   = readEn;
    assign bus.rd_valid     = vPipe[RD_LAT-1];
    assign bus.rd_sel       = vPipe[RD_LAT-1] ? sPipe[RD_LAT-1] : selHold;
    assign bus.busy         = (state != IDLE);
    assign bus.grant        = (state != IDLE) ? (3'b001 << gIdx) : 3'b000;
    assign bus.done         = doneNow ? (3'b001 << gIdx) : 3'b000;
endmodule
